// File: rtl/target_draw_ctrl.sv
// Sprite mover: erases the previously drawn sprite box, then draws it at the new origin.
// Latency: one pixel per cycle, plot is registered (1 cycle); done 2*SPR_W*SPR_H+1 cycles after start with erase, SPR_W*SPR_H+1 without.
// Backpressure: none; start is accepted only in IDLE and dropped (not queued) while busy.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start, new_x, new_y        move/draw request and requested sprite origin
//   gfx_x, gfx_y               origin presented to the sprite graphic LUT
//   flush_x, flush_y           pixel being scanned, presented to the LUT
//   pix_colour, pix_enable     same-cycle LUT colour and opaque flag for (flush_x, flush_y)
//   vga_x, vga_y, vga_colour   registered pixel write
//   plot                       pixel write strobe
//   busy, done                 activity flag and single-cycle completion pulse
module target_draw_ctrl #(
    parameter int          SPR_W     = 11,
    parameter int          SPR_H     = 8,
    parameter int          SCR_W     = 160,
    parameter int          SCR_H     = 120,
    parameter logic [5:0]  BG_COLOUR = 6'b000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  new_x,
    input  logic [7:0]  new_y,
    output logic [7:0]  gfx_x,
    output logic [7:0]  gfx_y,
    output logic [7:0]  flush_x,
    output logic [7:0]  flush_y,
    input  logic [5:0]  pix_colour,
    input  logic        pix_enable,
    output logic [7:0]  vga_x,
    output logic [7:0]  vga_y,
    output logic [5:0]  vga_colour,
    output logic        plot,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ERASE = 2'd1;
    localparam logic [1:0] S_DRAW  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int DX_W = $clog2(SPR_W + 1);
    localparam int DY_W = $clog2(SPR_H + 1);

    localparam logic [DX_W-1:0] DX_LAST = DX_W'(SPR_W - 1);
    localparam logic [DY_W-1:0] DY_LAST = DY_W'(SPR_H - 1);

    // Screen limits in the 9-bit sum domain so the compare never truncates.
    localparam logic [8:0] SCR_W_LIM = 9'(SCR_W);
    localparam logic [8:0] SCR_H_LIM = 9'(SCR_H);

    logic [1:0]       state;
    logic [DX_W-1:0]  dx;
    logic [DY_W-1:0]  dy;
    logic             drawn_valid;
    logic [7:0]       old_x;
    logic [7:0]       old_y;
    logic [7:0]       cur_x;
    logic [7:0]       cur_y;

    // Last LUT address driven while scanning; replayed outside the scan states.
    logic [7:0]       gfx_x_hold;
    logic [7:0]       gfx_y_hold;
    logic [7:0]       flush_x_hold;
    logic [7:0]       flush_y_hold;

    logic             scanning;
    logic             erasing;
    logic [7:0]       base_x;
    logic [7:0]       base_y;
    logic [8:0]       sum_x;
    logic [8:0]       sum_y;
    logic             on_screen;
    logic             last_col;
    logic             last_row;

    // ------------------------------------------------------------------
    // Scan address generation
    // ------------------------------------------------------------------
    always_comb begin
        scanning  = (state == S_ERASE) || (state == S_DRAW);
        erasing   = (state == S_ERASE);
        base_x    = erasing ? old_x : cur_x;
        base_y    = erasing ? old_y : cur_y;
        sum_x     = {1'b0, base_x} + {{(9-DX_W){1'b0}}, dx};
        sum_y     = {1'b0, base_y} + {{(9-DY_W){1'b0}}, dy};
        // A carry means the pixel wrapped past column/row 255: never draw it.
        on_screen = !sum_x[8] && !sum_y[8] &&
                    (sum_x < SCR_W_LIM) && (sum_y < SCR_H_LIM);
        last_col  = (dx == DX_LAST);
        last_row  = (dy == DY_LAST);
    end

    always_comb begin
        gfx_x   = gfx_x_hold;
        gfx_y   = gfx_y_hold;
        flush_x = flush_x_hold;
        flush_y = flush_y_hold;
        if (scanning) begin
            gfx_x   = base_x;
            gfx_y   = base_y;
            flush_x = sum_x[7:0];
            flush_y = sum_y[7:0];
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // ------------------------------------------------------------------
    // Control and pixel pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            dx           <= '0;
            dy           <= '0;
            drawn_valid  <= 1'b0;
            old_x        <= 8'd0;
            old_y        <= 8'd0;
            cur_x        <= 8'd0;
            cur_y        <= 8'd0;
            gfx_x_hold   <= 8'd0;
            gfx_y_hold   <= 8'd0;
            flush_x_hold <= 8'd0;
            flush_y_hold <= 8'd0;
            vga_x        <= 8'd0;
            vga_y        <= 8'd0;
            vga_colour   <= BG_COLOUR;
            plot         <= 1'b0;
        end else begin
            // Strobe only follows a scan cycle; the write data otherwise holds.
            plot <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        cur_x <= new_x;
                        cur_y <= new_y;
                        dx    <= '0;
                        dy    <= '0;
                        // Nothing on screen yet after reset: skip the erase pass.
                        state <= drawn_valid ? S_ERASE : S_DRAW;
                    end
                end

                S_ERASE, S_DRAW: begin
                    gfx_x_hold   <= base_x;
                    gfx_y_hold   <= base_y;
                    flush_x_hold <= sum_x[7:0];
                    flush_y_hold <= sum_y[7:0];

                    vga_x      <= sum_x[7:0];
                    vga_y      <= sum_y[7:0];
                    vga_colour <= erasing ? BG_COLOUR : pix_colour;
                    plot       <= pix_enable && on_screen;

                    if (!last_col) begin
                        dx <= dx + 1'b1;
                    end else begin
                        dx <= '0;
                        if (!last_row) begin
                            dy <= dy + 1'b1;
                        end else begin
                            dy    <= '0;
                            state <= erasing ? S_DRAW : S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    // The box just drawn becomes the one to erase on the next move.
                    old_x       <= cur_x;
                    old_y       <= cur_y;
                    drawn_valid <= 1'b1;
                    state       <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_target_draw_ctrl.sv
module tb_target_draw_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] new_x = 8'd0;
    logic [7:0] new_y = 8'd0;
    logic [7:0] gfx_x, gfx_y, flush_x, flush_y;
    logic [5:0] pix_colour;
    logic       pix_enable;
    logic [7:0] vga_x, vga_y;
    logic [5:0] vga_colour;
    logic       plot, busy, done;

    target_draw_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .new_x      (new_x),
        .new_y      (new_y),
        .gfx_x      (gfx_x),
        .gfx_y      (gfx_y),
        .flush_x    (flush_x),
        .flush_y    (flush_y),
        .pix_colour (pix_colour),
        .pix_enable (pix_enable),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Sprite LUT: pixel (rx,ry) inside the box is opaque unless (rx+ry) % 3 == 0.
    // An 11x8 box has 59 opaque pixels; its 5x5 top-left corner has 17.
    logic [7:0] lut_rx, lut_ry;
    always_comb begin
        lut_rx     = flush_x - gfx_x;
        lut_ry     = flush_y - gfx_y;
        pix_enable = ((int'(lut_rx) + int'(lut_ry)) % 3) != 0;
        pix_colour = {1'b1, lut_rx[2:0], lut_ry[1:0]};
    end

    int cnt = 0;
    always @(posedge clk) cnt <= cnt + 1;

    int total = 0;
    int bad   = 0;

    // Pass bookkeeping: t0 is the cycle start was presented (cycle 0).
    int         t0 = 0;
    logic       b_valid = 1'b0;
    logic [7:0] b_ox = 8'd0, b_oy = 8'd0;

    // Monitor: every plot must sit in the expected scan slot with expected data.
    logic       mon_active = 1'b0;
    logic       mon_erase  = 1'b0;
    logic [7:0] mon_ox, mon_oy, mon_nx, mon_ny;
    int         mon_err = 0;
    int         n_er = 0;
    int         n_dr = 0;
    int         mc, mk, mdb;
    logic [7:0] mdx, mdy, mex, mey;

    always @(negedge clk) begin
        if (plot === 1'b1) begin
            if (!mon_active) begin
                mon_err = mon_err + 1;
            end else begin
                mc  = cnt - t0;
                mdb = mon_erase ? 90 : 2;
                if (mon_erase && mc >= 2 && mc <= 89) begin
                    mk  = mc - 2;
                    mdx = 8'(mk % 11);
                    mdy = 8'(mk / 11);
                    mex = mon_ox + mdx;
                    mey = mon_oy + mdy;
                    if (vga_x !== mex || vga_y !== mey || vga_colour !== 6'b000000)
                        mon_err = mon_err + 1;
                    n_er = n_er + 1;
                end else if (mc >= mdb && mc <= mdb + 87) begin
                    mk  = mc - mdb;
                    mdx = 8'(mk % 11);
                    mdy = 8'(mk / 11);
                    mex = mon_nx + mdx;
                    mey = mon_ny + mdy;
                    if (vga_x !== mex || vga_y !== mey ||
                        vga_colour !== {1'b1, mdx[2:0], mdy[1:0]})
                        mon_err = mon_err + 1;
                    n_dr = n_dr + 1;
                end else begin
                    mon_err = mon_err + 1;
                end
                if (vga_x >= 8'd160 || vga_y >= 8'd120)
                    mon_err = mon_err + 1;
            end
        end
    end

    task automatic do_start(input logic [7:0] x, input logic [7:0] y);
        @(posedge clk);
        #1;
        start      = 1'b1;
        new_x      = x;
        new_y      = y;
        t0         = cnt;
        n_er       = 0;
        n_dr       = 0;
        mon_err    = 0;
        mon_erase  = b_valid;
        mon_ox     = b_ox;
        mon_oy     = b_oy;
        mon_nx     = x;
        mon_ny     = y;
        mon_active = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        b_ox    = x;
        b_oy    = y;
        b_valid = 1'b1;
    endtask

    task automatic wait_cyc(input int n);
        @(negedge clk);
        while ((cnt - t0) < n) @(negedge clk);
    endtask

    // Cycle of the done pulse relative to start, or -1 if it never came.
    task automatic wait_done(output int dc);
        dc = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dc = cnt - t0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (plot !== 1'b0) begin bad++; $display("FAIL rst_plot got=%b want=0", plot); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rst_busy_done got=%b%b want=00", busy, done); end
        total++; if (vga_x !== 8'd0 || vga_y !== 8'd0) begin bad++; $display("FAIL rst_vga_xy got=%0d,%0d want=0,0", vga_x, vga_y); end
        total++; if (vga_colour !== 6'b000000) begin bad++; $display("FAIL rst_colour got=%0h want=0", vga_colour); end
        total++; if (flush_x !== 8'd0 || flush_y !== 8'd0) begin bad++; $display("FAIL rst_flush got=%0d,%0d want=0,0", flush_x, flush_y); end
        total++; if (gfx_x !== 8'd0 || gfx_y !== 8'd0) begin bad++; $display("FAIL rst_gfx got=%0d,%0d want=0,0", gfx_x, gfx_y); end
        // reset wins over a simultaneous start
        @(posedge clk);
        #1;
        start = 1'b1; new_x = 8'd9; new_y = 8'd9;
        @(posedge clk);
        #1;
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_prio_busy got=%b want=0", busy); end
        b_valid = 1'b0;
    endtask

    task automatic test_first_draw;
        int dc;
        do_start(8'd20, 8'd30);
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL first_busy got=%b want=1", busy); end
        total++; if (gfx_x !== 8'd20 || gfx_y !== 8'd30) begin bad++; $display("FAIL first_gfx got=%0d,%0d want=20,30", gfx_x, gfx_y); end
        total++; if (flush_x !== 8'd20 || flush_y !== 8'd30) begin bad++; $display("FAIL first_flush got=%0d,%0d want=20,30", flush_x, flush_y); end
        wait_done(dc);
        total++; if (dc !== 89) begin bad++; $display("FAIL first_done_cycle got=%0d want=89", dc); end
        total++; if (plot !== 1'b1) begin bad++; $display("FAIL first_plot_at_done got=%b want=1", plot); end
        @(negedge clk);
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL first_done_width got=%b%b want=00", done, busy); end
        total++; if (n_dr !== 59 || n_er !== 0) begin bad++; $display("FAIL first_counts got=%0d/%0d want=59/0", n_dr, n_er); end
        total++; if (mon_err !== 0) begin bad++; $display("FAIL first_pixels got=%0d bad pixels want=0", mon_err); end
    endtask

    task automatic test_move(input logic [7:0] x, input logic [7:0] y, input string nm);
        int dc;
        logic [7:0] ox, oy;
        ox = b_ox;
        oy = b_oy;
        do_start(x, y);
        @(negedge clk);
        total++; if (gfx_x !== ox || flush_x !== ox || flush_y !== oy) begin bad++; $display("FAIL %s_erase_addr got=%0d,%0d,%0d want=%0d,%0d,%0d", nm, gfx_x, flush_x, flush_y, ox, ox, oy); end
        wait_cyc(89);
        total++; if (gfx_x !== x || gfx_y !== y || flush_x !== x) begin bad++; $display("FAIL %s_draw_addr got=%0d,%0d,%0d want=%0d,%0d,%0d", nm, gfx_x, gfx_y, flush_x, x, y, x); end
        wait_done(dc);
        total++; if (dc !== 177) begin bad++; $display("FAIL %s_done_cycle got=%0d want=177", nm, dc); end
        @(negedge clk);
        total++; if (n_er !== 59 || n_dr !== 59) begin bad++; $display("FAIL %s_counts got=%0d/%0d want=59/59", nm, n_er, n_dr); end
        total++; if (mon_err !== 0) begin bad++; $display("FAIL %s_pixels got=%0d bad pixels want=0", nm, mon_err); end
    endtask

    task automatic test_clipping;
        int dc;
        do_start(8'd155, 8'd115);
        wait_done(dc);
        total++; if (dc !== 177) begin bad++; $display("FAIL clip_done_cycle got=%0d want=177", dc); end
        @(negedge clk);
        total++; if (n_er !== 59 || n_dr !== 17) begin bad++; $display("FAIL clip_counts got=%0d/%0d want=59/17", n_er, n_dr); end
        total++; if (mon_err !== 0) begin bad++; $display("FAIL clip_pixels got=%0d bad pixels want=0", mon_err); end
        // Columns 250..260 wrap: the low byte 0..4 is on-screen but must not plot.
        do_start(8'd250, 8'd10);
        wait_done(dc);
        total++; if (dc !== 177) begin bad++; $display("FAIL wrap_done_cycle got=%0d want=177", dc); end
        @(negedge clk);
        total++; if (n_er !== 17 || n_dr !== 0) begin bad++; $display("FAIL wrap_counts got=%0d/%0d want=17/0", n_er, n_dr); end
        total++; if (mon_err !== 0) begin bad++; $display("FAIL wrap_pixels got=%0d bad pixels want=0", mon_err); end
        // Idle replays the last scanned address: dx=10,dy=7 from (250,10).
        total++; if (flush_x !== 8'd4 || flush_y !== 8'd17) begin bad++; $display("FAIL idle_flush got=%0d,%0d want=4,17", flush_x, flush_y); end
        total++; if (gfx_x !== 8'd250 || gfx_y !== 8'd10) begin bad++; $display("FAIL idle_gfx got=%0d,%0d want=250,10", gfx_x, gfx_y); end
    endtask

    task automatic test_busy_lockout;
        int dc;
        do_start(8'd60, 8'd60);
        wait_cyc(40);
        start = 1'b1; new_x = 8'd0; new_y = 8'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(dc);
        total++; if (dc !== 177) begin bad++; $display("FAIL lock_done_cycle got=%0d want=177", dc); end
        @(negedge clk);
        total++; if (n_er !== 0 || n_dr !== 59) begin bad++; $display("FAIL lock_counts got=%0d/%0d want=0/59", n_er, n_dr); end
        total++; if (mon_err !== 0) begin bad++; $display("FAIL lock_pixels got=%0d bad pixels want=0", mon_err); end
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL lock_no_queue got busy=%b want=0", busy); end
    endtask

    task automatic test_reset_mid_draw;
        int dc;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        b_valid = 1'b0;
        do_start(8'd30, 8'd30);
        wait_cyc(50);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mon_active = 1'b0;
        mon_err = 0;
        b_valid = 1'b0;
        @(negedge clk);
        total++; if (plot !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL abort_plot_busy got=%b%b want=00", plot, busy); end
        repeat (5) @(negedge clk);
        total++; if (mon_err !== 0) begin bad++; $display("FAIL abort_stray_plots got=%0d want=0", mon_err); end
        do_start(8'd70, 8'd70);
        wait_done(dc);
        total++; if (dc !== 89) begin bad++; $display("FAIL abort_redraw_done got=%0d want=89", dc); end
        @(negedge clk);
        total++; if (n_er !== 0 || n_dr !== 59) begin bad++; $display("FAIL abort_redraw_counts got=%0d/%0d want=0/59", n_er, n_dr); end
        total++; if (mon_err !== 0) begin bad++; $display("FAIL abort_redraw_pixels got=%0d bad pixels want=0", mon_err); end
    endtask

    initial begin
        test_reset();
        test_first_draw();
        test_move(8'd40, 8'd50, "move");
        test_move(8'd40, 8'd50, "same_pos");
        test_clipping();
        test_busy_lockout();
        test_reset_mid_draw();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
